// File: rtl/alif_config_sequencer.sv
// Configuration sequencer for the ALIF neuron system: serializes a 23-bit parameter frame, waits for params_ready, then runs.
// Optional WAIT_RDY timeout / ERROR path enabled by defining ALIF_SEQ_TIMEOUT_EN.
module alif_config_sequencer #(
  parameter int FRAME_BITS     = 23,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       start,
  input  logic       stop,
  input  logic [2:0] cfg_weight_a,
  input  logic [7:0] cfg_leak_rate,
  input  logic [7:0] cfg_threshold_min,
  input  logic [3:0] cfg_leak_cycles,
  input  logic       params_ready,
  output logic       load_mode,
  output logic       serial_data,
  output logic       input_enable,
  output logic       busy,
  output logic       running,
  output logic       cfg_error
);

  localparam int CNT_W = $clog2(FRAME_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_RDY,
    S_RUN,
    S_ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bitCnt_q, bitCnt_d;
  logic                  capture;
  logic                  timeoutHit;

  logic loadMode_q, loadMode_d;
  logic serialData_q, serialData_d;
  logic inputEnable_q, inputEnable_d;
  logic busy_q, busy_d;
  logic running_q, running_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      shift_q       <= '0;
      bitCnt_q      <= '0;
      loadMode_q    <= 1'b0;
      serialData_q  <= 1'b0;
      inputEnable_q <= 1'b0;
      busy_q        <= 1'b0;
      running_q     <= 1'b0;
    end else if (enable) begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bitCnt_q      <= bitCnt_d;
      loadMode_q    <= loadMode_d;
      serialData_q  <= serialData_d;
      inputEnable_q <= inputEnable_d;
      busy_q        <= busy_d;
      running_q     <= running_d;
    end
  end

  // Start wins over stop in RUN/ERROR; LOAD and WAIT_RDY ignore both so a frame always completes.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitCnt_d = bitCnt_q;
    capture  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) capture = 1'b1;
      end
      S_LOAD: begin
        if (bitCnt_q == '0) begin
          state_d = S_WAIT_RDY;
        end else begin
          shift_d  = shift_q << 1;
          bitCnt_d = bitCnt_q - 1'b1;
        end
      end
      S_WAIT_RDY: begin
        if (params_ready)    state_d = S_RUN;
        else if (timeoutHit) state_d = S_ERROR;
      end
      S_RUN, S_ERROR: begin
        if (start)     capture = 1'b1;
        else if (stop) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (capture) begin
      state_d  = S_LOAD;
      shift_d  = {cfg_weight_a, cfg_leak_rate, cfg_threshold_min, cfg_leak_cycles};
      bitCnt_d = CNT_W'(FRAME_BITS - 1);
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    loadMode_d    = (state_d == S_LOAD);
    serialData_d  = (state_d == S_LOAD) && shift_d[FRAME_BITS-1];
    inputEnable_d = (state_d == S_RUN);
    busy_d        = (state_d == S_LOAD) || (state_d == S_WAIT_RDY);
    running_d     = (state_d == S_RUN);
  end

`ifdef ALIF_SEQ_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] tmoCnt_q, tmoCnt_d;
  logic             cfgError_q, cfgError_d;

  always_comb begin
    tmoCnt_d   = '0;
    timeoutHit = 1'b0;
    if (state_q == S_WAIT_RDY && !params_ready) begin
      if (tmoCnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) timeoutHit = 1'b1;
      else                                        tmoCnt_d   = tmoCnt_q + 1'b1;
    end
  end

  // Sticky until the next capture; surviving a stop back to IDLE is intentional.
  always_comb begin
    cfgError_d = cfgError_q;
    if (capture)                 cfgError_d = 1'b0;
    else if (state_d == S_ERROR) cfgError_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmoCnt_q   <= '0;
      cfgError_q <= 1'b0;
    end else if (enable) begin
      tmoCnt_q   <= tmoCnt_d;
      cfgError_q <= cfgError_d;
    end
  end

  assign cfg_error = cfgError_q;
`else
  assign timeoutHit = 1'b0;
  assign cfg_error  = 1'b0;
`endif

  assign load_mode    = loadMode_q;
  assign serial_data  = serialData_q;
  assign input_enable = inputEnable_q;
  assign busy         = busy_q;
  assign running      = running_q;

endmodule

// File: tb/tb_alif_config_sequencer.sv
// Self-checking bench for alif_config_sequencer: random frames checked against a frame/timing model.
// Exercises the timeout path when ALIF_SEQ_TIMEOUT_EN is defined.
module tb_alif_config_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       start;
  logic       stop;
  logic [2:0] cfg_weight_a;
  logic [7:0] cfg_leak_rate;
  logic [7:0] cfg_threshold_min;
  logic [3:0] cfg_leak_cycles;
  logic       params_ready;
  logic       load_mode;
  logic       serial_data;
  logic       input_enable;
  logic       busy;
  logic       running;
  logic       cfg_error;

  int          compCount = 0;
  int          failCount = 0;
  logic [22:0] expFrame;
  logic        expErr;

  alif_config_sequencer #(.FRAME_BITS(23), .TIMEOUT_CYCLES(64)) dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .start             (start),
    .stop              (stop),
    .cfg_weight_a      (cfg_weight_a),
    .cfg_leak_rate     (cfg_leak_rate),
    .cfg_threshold_min (cfg_threshold_min),
    .cfg_leak_cycles   (cfg_leak_cycles),
    .params_ready      (params_ready),
    .load_mode         (load_mode),
    .serial_data       (serial_data),
    .input_enable      (input_enable),
    .busy              (busy),
    .running           (running),
    .cfg_error         (cfg_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected vector order: {load_mode, serial_data, input_enable, busy, running, cfg_error}
  task automatic checkOutput(input string tag, input logic [5:0] expected);
    logic [5:0] observed;
    observed = {load_mode, serial_data, input_enable, busy, running, cfg_error};
    compCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %b expected %b (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic pr);
    start        = st;
    stop         = sp;
    params_ready = pr;
    step();
  endtask

  task automatic noise();
    start             = 1'($urandom_range(0, 1));
    stop              = 1'($urandom_range(0, 1));
    params_ready      = 1'($urandom_range(0, 1));
    cfg_weight_a      = 3'($urandom);
    cfg_leak_rate     = 8'($urandom);
    cfg_threshold_min = 8'($urandom);
    cfg_leak_cycles   = 4'($urandom);
  endtask

  task automatic startFrame(input logic [2:0] w, input logic [7:0] lr, input logic [7:0] th,
                            input logic [3:0] lc, input logic withStop);
    cfg_weight_a      = w;
    cfg_leak_rate     = lr;
    cfg_threshold_min = th;
    cfg_leak_cycles   = lc;
    expFrame          = {w, lr, th, lc};
    enable            = 1'b1;
    applyStimulus(1'b1, withStop, 1'b0);
    start  = 1'b0;
    stop   = 1'b0;
    expErr = 1'b0;
    checkOutput("capture", {1'b1, expFrame[22], 4'b0100});
  endtask

  // Walks bits 21..0 with random noise on ignored inputs; optional stall after a bit, optional early abort.
  task automatic streamBits(input int stallAt, input int stallLen, input int abortAt);
    for (int k = 21; k >= 0; k--) begin
      noise();
      step();
      checkOutput("bit", {1'b1, expFrame[k], 4'b0100});
      if (k == abortAt) return;
      if (k == stallAt) begin
        enable = 1'b0;
        for (int j = 0; j < stallLen; j++) begin
          noise();
          step();
          checkOutput("stall_hold", {1'b1, expFrame[k], 4'b0100});
        end
        enable = 1'b1;
      end
    end
    noise();
    step();
    checkOutput("wait_entry", 6'b000100);
  endtask

  task automatic waitReady(input int delay);
    for (int d = 0; d < delay; d++) begin
      start = 1'($urandom_range(0, 1));
      stop  = 1'($urandom_range(0, 1));
      params_ready = 1'b0;
      step();
      checkOutput("wait_rdy", 6'b000100);
    end
    applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    start = 1'b0;
    stop  = 1'b0;
    checkOutput("run_entry", 6'b001010);
  endtask

  task automatic runHold(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      checkOutput("run_hold", 6'b001010);
    end
  endtask

  task automatic stopRun();
    applyStimulus(1'b0, 1'b1, 1'b0);
    stop = 1'b0;
    checkOutput("stop", {5'b00000, expErr});
  endtask

`ifdef ALIF_SEQ_TIMEOUT_EN
  task automatic timeoutRun();
    for (int i = 1; i < 64; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("timeout_wait", 6'b000100);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    expErr = 1'b1;
    checkOutput("timeout_err", 6'b000001);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("error_hold", 6'b000001);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; enable = 1'b1; start = 1'b0; stop = 1'b0; params_ready = 1'b0;
    cfg_weight_a = '0; cfg_leak_rate = '0; cfg_threshold_min = '0; cfg_leak_cycles = '0;
    expErr = 1'b0;
    expFrame = '0;
    step();
    step();
    reset = 1'b0;
    checkOutput("reset", 6'b000000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("idle_ignore", 6'b000000);
    end

    // Reference frame with a 5-cycle stall after bit 10 and ready two cycles into WAIT_RDY.
    startFrame(3'b101, 8'h3C, 8'h80, 4'h9, 1'b0);
    streamBits(10, 5, -1);
    waitReady(2);
    runHold(4);
    stopRun();

    // Start and stop together in RUN: reload wins.
    startFrame(3'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), 1'b0);
    streamBits(-1, 0, -1);
    waitReady(0);
    runHold(2);
    startFrame(3'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), 1'b1);
    streamBits(-1, 0, -1);
    waitReady(1);
    stopRun();

    for (int iter = 0; iter < 6; iter++) begin
      startFrame(3'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
                 1'($urandom_range(0, 1)));
      streamBits($urandom_range(0, 1) ? int'($urandom_range(0, 21)) : -1,
                 int'($urandom_range(1, 6)), -1);
      waitReady(int'($urandom_range(0, 40)));
      runHold(int'($urandom_range(1, 5)));
      if ($urandom_range(0, 1) == 1) stopRun();
    end
    stopRun();

    // Reset mid-frame after bit 12; nothing runs until a fresh frame completes.
    startFrame(3'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), 1'b0);
    streamBits(-1, 0, 12);
    reset = 1'b1;
    step();
    reset = 1'b0;
    expErr = 1'b0;
    checkOutput("mid_reset", 6'b000000);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("post_reset_idle", 6'b000000);
    end
    startFrame(3'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), 1'b0);
    streamBits(-1, 0, -1);
    waitReady(0);
    stopRun();

`ifdef ALIF_SEQ_TIMEOUT_EN
    startFrame(3'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), 1'b0);
    streamBits(-1, 0, -1);
    timeoutRun();
    stopRun();
    startFrame(3'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), 1'b0);
    streamBits(-1, 0, -1);
    timeoutRun();
    startFrame(3'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), 1'b0);
    streamBits(-1, 0, -1);
    waitReady(5);
    stopRun();
`else
    startFrame(3'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), 1'b0);
    streamBits(-1, 0, -1);
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("no_timeout", 6'b000100);
    end
    waitReady(0);
    stopRun();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
